// File: rtl/adaptive_dc_stream_top.sv
// Multi-channel streaming DC-offset remover: a per-channel leaky integrator tracks each
// channel's offset, and the offset is subtracted in a two-register ready/valid pipeline.
module adaptive_dc_stream_top #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int SHIFT      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_axis_valid,
   output logic                         s_axis_ready,
   input  logic signed [DATA_WIDTH-1:0] s_axis_data,
   input  logic [CH_WIDTH-1:0]          s_axis_chan,
   output logic                         m_axis_valid,
   input  logic                         m_axis_ready,
   output logic signed [DATA_WIDTH-1:0] m_axis_data,
   output logic [CH_WIDTH-1:0]          m_axis_chan,
   input  logic                         cfg_bypass,
   input  logic                         cfg_freeze,
   input  logic                         cfg_clear,
   output logic [15:0]                  stat_sat_count
);

   localparam int AW = DATA_WIDTH + SHIFT + 1;
   localparam int DW = DATA_WIDTH + 2;
   localparam logic signed [DW-1:0] DMAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DW-1:0] DMIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

   logic                         adv_s;
   logic                         valid_a_r;
   logic signed [DATA_WIDTH-1:0] x_a_r;
   logic [CH_WIDTH-1:0]          ch_a_r;
   logic signed [AW-1:0]         acc_r [NUM_CH];
   logic signed [AW-1:0]         acc_sel_s;
   logic signed [AW-1:0]         dc_s;
   logic signed [AW-1:0]         next_acc_s;
   logic signed [DW-1:0]         diff_s;
   logic signed [DATA_WIDTH-1:0] y_s;
   logic                         clipped_s;
   logic                         in_range_s;
   logic                         adapt_s;

   assign adv_s        = !m_axis_valid || m_axis_ready;
   assign s_axis_ready = adv_s && rst_n;

   // Stage A datapath: select the channel's accumulator, subtract its estimate, clip.
   always_comb begin
      acc_sel_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(ch_a_r) == c) begin
            acc_sel_s = acc_r[c];
         end else begin
            acc_sel_s = acc_sel_s;
         end
      end
      in_range_s = (int'(ch_a_r) < NUM_CH);
      dc_s       = acc_sel_s >>> SHIFT;
      diff_s     = DW'(x_a_r) - DW'(dc_s);
      next_acc_s = acc_sel_s + AW'(x_a_r) - dc_s;
      adapt_s    = valid_a_r && !cfg_bypass && !cfg_freeze && !cfg_clear && in_range_s;
      if (cfg_bypass || !in_range_s) begin
         y_s       = x_a_r;
         clipped_s = 1'b0;
      end else if (diff_s > DMAX) begin
         y_s       = DMAX[DATA_WIDTH-1:0];
         clipped_s = 1'b1;
      end else if (diff_s < DMIN) begin
         y_s       = DMIN[DATA_WIDTH-1:0];
         clipped_s = 1'b1;
      end else begin
         y_s       = diff_s[DATA_WIDTH-1:0];
         clipped_s = 1'b0;
      end
   end

   // Accumulators: clear is level-sensitive and wins over adaptation on every edge.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (!rst_n || cfg_clear) begin
            acc_r[c] <= '0;
         end else if (adv_s && adapt_s && (int'(ch_a_r) == c)) begin
            acc_r[c] <= next_acc_s;
         end
      end
   end

   // Pipeline registers and saturation statistics; everything holds while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_a_r      <= 1'b0;
         x_a_r          <= '0;
         ch_a_r         <= '0;
         m_axis_valid   <= 1'b0;
         m_axis_data    <= '0;
         m_axis_chan    <= '0;
         stat_sat_count <= 16'd0;
      end else if (adv_s) begin
         valid_a_r <= s_axis_valid;
         if (s_axis_valid) begin
            x_a_r  <= s_axis_data;
            ch_a_r <= s_axis_chan;
         end
         m_axis_valid <= valid_a_r;
         m_axis_data  <= y_s;
         m_axis_chan  <= ch_a_r;
         if (valid_a_r && clipped_s && (stat_sat_count != 16'hFFFF)) begin
            stat_sat_count <= stat_sat_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adaptive_dc_stream_top.sv
// Directed bench for adaptive_dc_stream_top with three channels, so tag 3 exercises
// the out-of-range pass-through; random section uses an integer reference model.
module tb_adaptive_dc_stream_top;
   localparam int W = 16, NCH = 3, CHW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n, s_axis_valid, s_axis_ready, m_axis_valid, m_axis_ready;
   logic signed [W-1:0] s_axis_data, m_axis_data;
   logic [CHW-1:0]      s_axis_chan, m_axis_chan;
   logic                cfg_bypass, cfg_freeze, cfg_clear;
   logic [15:0]         stat_sat_count;
   logic                man_ready = 1'b0, rnd_ready = 1'b0;
   bit                  rnd_en = 1'b0;

   assign m_axis_ready = rnd_en ? rnd_ready : man_ready;

   adaptive_dc_stream_top #(.DATA_WIDTH(W), .NUM_CH(NCH), .SHIFT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
      .s_axis_data(s_axis_data), .s_axis_chan(s_axis_chan),
      .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_chan(m_axis_chan),
      .cfg_bypass(cfg_bypass), .cfg_freeze(cfg_freeze), .cfg_clear(cfg_clear),
      .stat_sat_count(stat_sat_count));

   int checks = 0, errors = 0;
   typedef struct {logic [CHW-1:0] ch; logic signed [W-1:0] d;} smp_t;
   typedef struct {int ch; int x; int y;} vec_t;
   smp_t got_q[$];
   smp_t exp_q[$];
   longint macc [4];

   initial begin
      forever begin
         @(posedge clk); #1;
         rnd_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor: collects transfers and checks data holds while stalled.
   logic stall_prev = 1'b0;
   smp_t held;
   always @(negedge clk) begin
      if (rst_n && stall_prev) begin
         checks++;
         if (!m_axis_valid || m_axis_data !== held.d || m_axis_chan !== held.ch) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b ch%0d %0d, held ch%0d %0d",
                     m_axis_valid, m_axis_chan, m_axis_data, held.ch, held.d);
         end
      end
      stall_prev = m_axis_valid && !m_axis_ready && rst_n;
      held = '{m_axis_chan, m_axis_data};
      if (m_axis_valid && m_axis_ready) got_q.push_back('{m_axis_chan, m_axis_data});
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_out(input string name, input int ch, input int d);
      smp_t s;
      checks++;
      if (got_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no output, expected ch%0d %0d", name, ch, d);
      end else begin
         s = got_q.pop_front();
         if (int'(s.ch) != ch || int'(s.d) != d) begin
            errors++;
            $display("FAIL %s: got ch%0d %0d expected ch%0d %0d", name, s.ch, s.d, ch, d);
         end
      end
   endtask

   task automatic send(input int ch, input int d);
      int n = 0;
      s_axis_valid = 1'b1;
      s_axis_chan  = CHW'(ch);
      s_axis_data  = W'(d);
      @(negedge clk);
      while (!s_axis_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_axis_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: ready=%0b expected 1 within 100 cycles", s_axis_ready);
      end
      @(posedge clk); #1;
      s_axis_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_pulse();
      cfg_clear = 1'b1;
      idle(2);
      cfg_clear = 1'b0;
   endtask

   function automatic int model(input int ch, input int x, output bit clip);
      longint dc, d;
      clip = 1'b0;
      if (ch >= NCH) return x;
      dc = macc[ch] >>> 4;
      d  = longint'(x) - dc;
      if (d > 32767) begin d = 32767; clip = 1'b1; end
      else if (d < -32768) begin d = -32768; clip = 1'b1; end
      macc[ch] = macc[ch] + longint'(x) - dc;
      return int'(d);
   endfunction

   vec_t vecs[12];

   initial begin
      bit   clip;
      int   clips, ch, x, y;
      smp_t g, e;

      vecs = '{'{0, 1000, 1000}, '{0, 1000, 938}, '{0, 1000, 879}, '{1, -500, -500},
               '{0, 1000, 824}, '{1, -500, -468}, '{1, -500, -439}, '{2, 0, 0},
               '{3, 7, 7}, '{2, 16, 16}, '{3, -32768, -32768}, '{2, -32768, -32768}};

      rst_n = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0; s_axis_chan = '0;
      cfg_bypass = 1'b0; cfg_freeze = 1'b0; cfg_clear = 1'b0; man_ready = 1'b1;
      idle(3);
      chk("rst_m_valid", m_axis_valid, 0);
      chk("rst_s_ready", s_axis_ready, 0);
      chk("rst_m_data", m_axis_data, 0);
      chk("rst_m_chan", m_axis_chan, 0);
      chk("rst_stat", stat_sat_count, 0);
      rst_n = 1'b1;
      #1 chk("ready_after_rst", s_axis_ready, 1);

      // Latency: transfer at edge N, visible after edge N+1.
      send(3, 5);
      chk("lat_not_yet", m_axis_valid, 0);
      idle(1);
      chk("lat_valid", m_axis_valid, 1);
      chk("lat_data", m_axis_data, 5);
      idle(1);
      check_out("lat_out", 3, 5);

      // Back-to-back table: DC step, interleaving, pass-through tag, negative clip.
      foreach (vecs[i]) send(vecs[i].ch, vecs[i].x);
      idle(3);
      foreach (vecs[i]) check_out($sformatf("vec%0d", i), vecs[i].ch, vecs[i].y);
      chk("stat_neg_clip", stat_sat_count, 1);

      clear_pulse();
      send(0, 1000);
      send(2, 100);
      idle(2);
      check_out("clear_ch0", 0, 1000);
      check_out("clear_ch2", 2, 100);

      cfg_freeze = 1'b1;
      send(0, 1000); send(0, 1000); send(0, 1000);
      idle(2);
      cfg_freeze = 1'b0;
      send(0, 1000); send(0, 1000);
      idle(2);
      check_out("freeze0", 0, 938);
      check_out("freeze1", 0, 938);
      check_out("freeze2", 0, 938);
      check_out("unfreeze0", 0, 938);
      check_out("unfreeze1", 0, 879);

      cfg_bypass = 1'b1;
      send(0, -1234);
      send(2, 32767);
      idle(2);
      cfg_bypass = 1'b0;
      send(0, 1000);
      idle(2);
      check_out("bypass0", 0, -1234);
      check_out("bypass1", 2, 32767);
      check_out("after_bypass", 0, 824);
      chk("stat_bypass", stat_sat_count, 1);

      // Stall: B full, A full, third sample must wait then move with the output.
      man_ready = 1'b0;
      send(3, 11);
      send(3, 22);
      s_axis_valid = 1'b1; s_axis_chan = 2'd3; s_axis_data = 16'sd33;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("stall_s_ready", s_axis_ready, 0);
         chk("stall_m_data", m_axis_data, 11);
      end
      man_ready = 1'b1;
      #1 chk("unstall_s_ready", s_axis_ready, 1);
      idle(1);
      s_axis_valid = 1'b0;
      chk("unstall_m_data", m_axis_data, 22);
      idle(3);
      check_out("stall0", 3, 11);
      check_out("stall1", 3, 22);
      check_out("stall2", 3, 33);

      // Positive saturation after the estimate settles at the negative rail.
      clear_pulse();
      for (int i = 0; i < 1000; i++) send(1, -32768);
      idle(3);
      got_q.delete();
      chk("stat_before_sat", stat_sat_count, 1);
      send(1, 32767);
      idle(2);
      check_out("sat_pos", 1, 32767);
      chk("stat_after_sat", stat_sat_count, 2);

      // Random traffic under random backpressure against the reference model.
      clear_pulse();
      foreach (macc[i]) macc[i] = 0;
      got_q.delete();
      exp_q.delete();
      clips = 0;
      rnd_en = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         ch = $urandom_range(0, 3);
         x  = int'($signed(16'($urandom)));
         y  = model(ch, x, clip);
         if (clip) clips++;
         exp_q.push_back('{CHW'(ch), W'(y)});
         send(ch, x);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      rnd_en = 1'b0;
      idle(4);
      chk("rand_count", got_q.size(), 2000);
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g.ch !== e.ch || g.d !== e.d) begin
            errors++;
            $display("FAIL rand_sample: got ch%0d %0d expected ch%0d %0d", g.ch, g.d, e.ch, e.d);
         end
      end
      chk("rand_stat", stat_sat_count, 2 + clips);

      // Reset with two samples in flight: nothing may be emitted afterwards.
      man_ready = 1'b0;
      send(0, 100);
      send(0, 200);
      rst_n = 1'b0;
      #1 chk("rst_mid_s_ready", s_axis_ready, 0);
      idle(1);
      chk("rst_mid_m_valid", m_axis_valid, 0);
      chk("rst_mid_stat", stat_sat_count, 0);
      chk("rst_mid_m_data", m_axis_data, 0);
      rst_n = 1'b1;
      man_ready = 1'b1;
      idle(3);
      chk("rst_discard", got_q.size(), 0);
      send(0, 1000);
      idle(2);
      check_out("post_rst", 0, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
